// File: rtl/control_execute_mc.sv
// Execute-stage sequencer: pops one instruction, runs it for its op-class latency,
// then writes the result once writeback accepts it. Resolves branches, obeys global stall.
module control_execute_mc #(
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic StallIn,
  input  logic DecExeValid,
  input  logic IsMul,
  input  logic IsBranch,
  input  logic BranchTaken,
  input  logic ExeWBReady,
  output logic DecExeBufferRd,
  output logic OperandLatch,
  output logic MulEn,
  output logic ExeWBBufferWr,
  output logic BranchResolve,
  output logic BranchFlush,
  output logic Busy
);

  if (ALU_LAT < 1 || MUL_LAT < 1 || ALU_LAT > 2**CNT_W || MUL_LAT > 2**CNT_W) begin : g_bad_params
    $error("control_execute_mc: latencies must be in 1..2**CNT_W");
  end

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXEC    = 2'b01,
    HOLD    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] ALU_LD = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_is_mul, w_is_mul_nxt;
  logic             r_is_branch, w_is_branch_nxt;
  // Low for exactly the first cycle after reset release; keeps every output quiet there.
  logic             r_live;
  logic             w_go;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= FETCH;
      r_cnt       <= '0;
      r_is_mul    <= 1'b0;
      r_is_branch <= 1'b0;
      r_live      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_is_mul    <= w_is_mul_nxt;
      r_is_branch <= w_is_branch_nxt;
      r_live      <= 1'b1;
    end
  end

  assign w_go = r_live && !StallIn;
  assign Busy = (r_state == EXEC) || (r_state == HOLD);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_is_mul_nxt    = r_is_mul;
    w_is_branch_nxt = r_is_branch;
    DecExeBufferRd  = 1'b0;
    OperandLatch    = 1'b0;
    MulEn           = 1'b0;
    ExeWBBufferWr   = 1'b0;
    BranchResolve   = 1'b0;
    BranchFlush     = 1'b0;
    case (r_state)
      FETCH: begin
        if (w_go && DecExeValid) begin
          DecExeBufferRd  = 1'b1;
          OperandLatch    = 1'b1;
          w_is_mul_nxt    = IsMul;
          w_is_branch_nxt = IsBranch;
          w_cnt_nxt       = IsMul ? MUL_LD : ALU_LD;
          w_state_nxt     = EXEC;
        end
      end
      EXEC: begin
        if (w_go) begin
          MulEn = r_is_mul;
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - ONE;
          end else if (r_is_branch) begin
            BranchResolve = 1'b1;
            BranchFlush   = BranchTaken;
            w_state_nxt   = FETCH;
          end else if (ExeWBReady) begin
            ExeWBBufferWr = 1'b1;
            w_state_nxt   = FETCH;
          end else begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_go && ExeWBReady) begin
          ExeWBBufferWr = 1'b1;
          w_state_nxt   = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_execute_mc.sv
// Bench for control_execute_mc: directed scenarios plus randomized traffic, all checked
// against an instruction-level model that tracks remaining execute work per instruction.
module tb_control_execute_mc;

  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 4;

  logic CLK;
  logic RST_N;
  logic StallIn, DecExeValid, IsMul, IsBranch, BranchTaken, ExeWBReady;
  logic DecExeBufferRd, OperandLatch, MulEn, ExeWBBufferWr, BranchResolve, BranchFlush, Busy;

  int n_checks;
  int n_errors;

  // Model: one instruction in flight with a count of execute cycles still owed.
  bit m_live;
  bit m_in_flight;
  int m_left;
  bit m_mul;
  bit m_br;

  logic o_rd, o_wr, o_mul, o_busy, o_res, o_fl;

  control_execute_mc #(.ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .StallIn(StallIn), .DecExeValid(DecExeValid),
    .IsMul(IsMul), .IsBranch(IsBranch), .BranchTaken(BranchTaken), .ExeWBReady(ExeWBReady),
    .DecExeBufferRd(DecExeBufferRd), .OperandLatch(OperandLatch), .MulEn(MulEn),
    .ExeWBBufferWr(ExeWBBufferWr), .BranchResolve(BranchResolve), .BranchFlush(BranchFlush),
    .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    StallIn = 0; DecExeValid = 0; IsMul = 0; IsBranch = 0; BranchTaken = 0; ExeWBReady = 1;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic tick();
    logic e_rd, e_mul, e_wr, e_res, e_fl, e_busy;
    #2;
    e_rd = 0; e_mul = 0; e_wr = 0; e_res = 0; e_fl = 0;
    e_busy = RST_N && m_in_flight;
    if (RST_N && m_live && !StallIn) begin
      if (!m_in_flight) begin
        e_rd = DecExeValid;
      end else if (m_left > 0) begin
        e_mul = m_mul;
        if (m_left == 1) begin
          if (m_br) begin
            e_res = 1;
            e_fl  = BranchTaken;
          end else begin
            e_wr = ExeWBReady;
          end
        end
      end else begin
        e_wr = ExeWBReady;
      end
    end
    chk("rd", DecExeBufferRd, e_rd);
    chk("oplatch", OperandLatch, e_rd);
    chk("mulen", MulEn, e_mul);
    chk("wr", ExeWBBufferWr, e_wr);
    chk("resolve", BranchResolve, e_res);
    chk("flush", BranchFlush, e_fl);
    chk("busy", Busy, e_busy);
    o_rd = DecExeBufferRd; o_wr = ExeWBBufferWr; o_mul = MulEn;
    o_busy = Busy; o_res = BranchResolve; o_fl = BranchFlush;
    @(posedge CLK);
    if (!RST_N) begin
      m_live = 0; m_in_flight = 0; m_left = 0; m_mul = 0; m_br = 0;
    end else if (!m_live) begin
      m_live = 1;
    end else if (!StallIn) begin
      if (!m_in_flight) begin
        if (DecExeValid) begin
          m_in_flight = 1;
          m_left = IsMul ? MUL_LAT : ALU_LAT;
          m_mul = IsMul;
          m_br = IsBranch;
        end
      end else if (m_left > 1) begin
        m_left--;
      end else if (m_left == 1) begin
        m_left = 0;
        if (m_br || ExeWBReady) m_in_flight = 0;
      end else if (ExeWBReady) begin
        m_in_flight = 0;
      end
    end
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_live = 0; m_in_flight = 0; m_left = 0; m_mul = 0; m_br = 0;
    clr_in();
    RST_N = 0;
    DecExeValid = 1;
    @(posedge CLK); #1;
    #2;
    chk("reset_rd", DecExeBufferRd, 1'b0);
    chk("reset_wr", ExeWBBufferWr, 1'b0);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_oplatch", OperandLatch, 1'b0);
    @(posedge CLK); #1;

    // First cycle after release is quiet even with a valid instruction waiting.
    RST_N = 1; DecExeValid = 1; IsMul = 0; ExeWBReady = 1;
    tick();
    chk("post_rst_rd", o_rd, 1'b0);

    // Back-to-back ALU ops: pop on even cycles, write on odd.
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("alu_rd", o_rd, (i % 2) == 0);
      chk("alu_wr", o_wr, (i % 2) == 1);
      chk("alu_busy", o_busy, (i % 2) == 1);
    end

    // Multiply then an ALU op popped right after it.
    for (int i = 0; i < 7; i++) begin
      clr_in();
      DecExeValid = (i == 0 || i == 5);
      IsMul = (i == 0);
      tick();
      chk("mul_mulen", o_mul, i >= 1 && i <= 4);
      chk("mul_wr", o_wr, i == 4 || i == 6);
      chk("mul_rd", o_rd, i == 0 || i == 5);
    end

    // ALU op finishing while writeback is not ready.
    for (int i = 0; i < 6; i++) begin
      clr_in();
      DecExeValid = (i == 0);
      ExeWBReady = !(i >= 1 && i <= 3);
      tick();
      chk("hold_wr", o_wr, i == 4);
      chk("hold_busy", o_busy, i >= 1 && i <= 4);
    end

    // Taken then not-taken branch.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        clr_in();
        DecExeValid = (i == 0);
        IsBranch = 1;
        BranchTaken = (k == 0);
        tick();
        chk("br_resolve", o_res, i == 1);
        chk("br_flush", o_fl, (k == 0) && (i == 1));
        chk("br_wr", o_wr, 1'b0);
      end
    end

    // Multiply stalled for two cycles mid-count.
    for (int i = 0; i < 8; i++) begin
      clr_in();
      DecExeValid = (i == 0);
      IsMul = 1;
      StallIn = (i == 2 || i == 3);
      tick();
      chk("stall_mulen", o_mul, i == 1 || (i >= 4 && i <= 6));
      chk("stall_wr", o_wr, i == 6);
      chk("stall_busy", o_busy, i >= 1 && i <= 6);
    end

    // Stall coinciding with a branch's final cycle delays the resolve.
    for (int i = 0; i < 3; i++) begin
      clr_in();
      DecExeValid = (i == 0);
      IsBranch = 1;
      BranchTaken = 1;
      StallIn = (i == 1);
      tick();
      chk("stall_br_resolve", o_res, i == 2);
      chk("stall_br_flush", o_fl, i == 2);
    end

    // Asynchronous reset during cycle 2 of a multiply.
    clr_in();
    DecExeValid = 1; IsMul = 1;
    tick();
    clr_in();
    tick();
    #1;
    RST_N = 0;
    #1;
    chk("arst_busy", Busy, 1'b0);
    chk("arst_mulen", MulEn, 1'b0);
    chk("arst_wr", ExeWBBufferWr, 1'b0);
    tick();
    RST_N = 1; DecExeValid = 1; IsMul = 0; ExeWBReady = 1;
    tick();
    chk("arst_rel_rd", o_rd, 1'b0);
    chk("arst_rel_wr", o_wr, 1'b0);
    tick();
    chk("arst_pop", o_rd, 1'b1);
    chk("arst_pop_wr", o_wr, 1'b0);
    DecExeValid = 0;
    tick();
    chk("arst_alu_wr", o_wr, 1'b1);
    chk("arst_alu_mulen", o_mul, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      DecExeValid = ($urandom_range(9) < 7);
      IsMul       = ($urandom_range(9) < 4);
      IsBranch    = ($urandom_range(3) == 0);
      BranchTaken = $urandom_range(1);
      ExeWBReady  = ($urandom_range(9) < 6);
      StallIn     = ($urandom_range(9) < 2);
      RST_N       = ($urandom_range(99) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
